// File: rtl/data_memory_arbiter.sv
// Round-robin arbiter sharing one data memory between port A (CPU) and port B (debug).
// Optional address range check: define DATA_MEM_ARB_RANGE_CHECK_EN.
module data_memory_arbiter #(
    parameter int DATA_W        = 32,
    parameter int ADDR_W        = 32,
    parameter int DEPTH         = 16,
    parameter int ACCESS_CYCLES = 1
) (
    input  logic              clock_in,
    input  logic              reset,
    input  logic              a_req,
    input  logic              a_write,
    input  logic [ADDR_W-1:0] a_address,
    input  logic [DATA_W-1:0] a_write_data,
    output logic              a_ack,
    output logic [DATA_W-1:0] a_read_data,
    output logic              a_error,
    input  logic              b_req,
    input  logic              b_write,
    input  logic [ADDR_W-1:0] b_address,
    input  logic [DATA_W-1:0] b_write_data,
    output logic              b_ack,
    output logic [DATA_W-1:0] b_read_data,
    output logic              b_error,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_write,
    output logic              mem_read,
    input  logic [DATA_W-1:0] mem_read_data,
    output logic              busy,
    output logic              owner_b
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    localparam int CW = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(ACCESS_CYCLES - 1);

    if (ACCESS_CYCLES < 1 || DEPTH < 1) begin : gBadParams
        $error("ACCESS_CYCLES and DEPTH must be at least 1");
    end

    logic [1:0]        state;
    logic [CW-1:0]     count;
    logic              lastGrantB;
    logic              ownerB;
    logic              errFlag;
    logic [ADDR_W-1:0] latchedAddr;
    logic [DATA_W-1:0] latchedData;
    logic              latchedWrite;
    logic [DATA_W-1:0] aReadData;
    logic [DATA_W-1:0] bReadData;

    logic              grantB;
    logic              reqWrite;
    logic [ADDR_W-1:0] reqAddr;
    logic [DATA_W-1:0] reqData;
    logic              outOfRange;

    // On a tie the port that was not served last wins
    assign grantB   = b_req & (~a_req | ~lastGrantB);
    assign reqWrite = grantB ? b_write : a_write;
    assign reqAddr  = grantB ? b_address : a_address;
    assign reqData  = grantB ? b_write_data : a_write_data;

`ifdef DATA_MEM_ARB_RANGE_CHECK_EN
    assign outOfRange = reqAddr >= ADDR_W'(DEPTH);
`else
    assign outOfRange = 1'b0;
`endif

    always_ff @(posedge clock_in) begin
        if (reset) begin
            state        <= IDLE;
            count        <= '0;
            lastGrantB   <= 1'b1;
            ownerB       <= 1'b0;
            errFlag      <= 1'b0;
            latchedAddr  <= '0;
            latchedData  <= '0;
            latchedWrite <= 1'b0;
            aReadData    <= '0;
            bReadData    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (a_req | b_req) begin
                        latchedAddr  <= reqAddr;
                        latchedData  <= reqData;
                        latchedWrite <= reqWrite;
                        ownerB       <= grantB;
                        errFlag      <= outOfRange;
                        count        <= '0;
                        if (outOfRange) begin
                            state <= RESP;
                            if (grantB) bReadData <= '0;
                            else        aReadData <= '0;
                        end else begin
                            state <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    if (count == LAST) begin
                        state <= RESP;
                        if (!latchedWrite) begin
                            if (ownerB) bReadData <= mem_read_data;
                            else        aReadData <= mem_read_data;
                        end
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                RESP: begin
                    lastGrantB <= ownerB;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy           = state != IDLE;
    assign owner_b        = ownerB;
    assign mem_address    = latchedAddr;
    assign mem_write_data = latchedData;
    assign mem_write      = (state == ACCESS) & latchedWrite;
    assign mem_read       = (state == ACCESS) & ~latchedWrite;
    assign a_ack          = (state == RESP) & ~ownerB;
    assign b_ack          = (state == RESP) & ownerB;
    assign a_error        = a_ack & errFlag;
    assign b_error        = b_ack & errFlag;
    assign a_read_data    = aReadData;
    assign b_read_data    = bReadData;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Directed bench for data_memory_arbiter with a behavioural 64-word memory.
// Range-check expectations follow DATA_MEM_ARB_RANGE_CHECK_EN.
module tb_data_memory_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        a_req, a_write, b_req, b_write;
    logic [31:0] a_address, a_write_data, b_address, b_write_data;
    logic        a_ack, a_error, b_ack, b_error;
    logic [31:0] a_read_data, b_read_data;
    logic [31:0] mem_address, mem_write_data, mem_read_data;
    logic        mem_write, mem_read, busy, owner_b;

    logic        a3_req;
    logic [31:0] a3_address;
    logic        a3_ack, a3_error, b3_ack, b3_error;
    logic [31:0] a3_read_data, b3_read_data;
    logic [31:0] m3_address, m3_write_data, m3_read_data;
    logic        m3_write, m3_read, busy3, owner3;

    logic [31:0] memArr [0:63];

    int passCount = 0;
    int checkCount = 0;

    data_memory_arbiter dut (
        .clock_in(clk), .reset(reset),
        .a_req(a_req), .a_write(a_write),
        .a_address(a_address), .a_write_data(a_write_data),
        .a_ack(a_ack), .a_read_data(a_read_data), .a_error(a_error),
        .b_req(b_req), .b_write(b_write),
        .b_address(b_address), .b_write_data(b_write_data),
        .b_ack(b_ack), .b_read_data(b_read_data), .b_error(b_error),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_write(mem_write), .mem_read(mem_read),
        .mem_read_data(mem_read_data),
        .busy(busy), .owner_b(owner_b)
    );

    data_memory_arbiter #(.ACCESS_CYCLES(3)) dut3 (
        .clock_in(clk), .reset(reset),
        .a_req(a3_req), .a_write(1'b0),
        .a_address(a3_address), .a_write_data(32'h0),
        .a_ack(a3_ack), .a_read_data(a3_read_data), .a_error(a3_error),
        .b_req(1'b0), .b_write(1'b0),
        .b_address(32'h0), .b_write_data(32'h0),
        .b_ack(b3_ack), .b_read_data(b3_read_data), .b_error(b3_error),
        .mem_address(m3_address), .mem_write_data(m3_write_data),
        .mem_write(m3_write), .mem_read(m3_read),
        .mem_read_data(m3_read_data),
        .busy(busy3), .owner_b(owner3)
    );

    // Memory word i holds i after reset
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 64; i++) memArr[i] <= 32'(i);
        end else if (mem_write) begin
            memArr[mem_address[5:0]] <= mem_write_data;
        end
    end

    assign mem_read_data = memArr[mem_address[5:0]];
    assign m3_read_data  = memArr[m3_address[5:0]];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checkCount++;
        if (got === exp) passCount++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    task automatic doAccess(input string tag, input logic portB,
                            input logic wr, input logic [31:0] addr,
                            input logic [31:0] wdata, input int expLat,
                            input int expStrobes, input logic [31:0] expAddr,
                            input logic [31:0] expRead, input logic expErr);
        int cyc = 0;
        int strobes = 0;
        logic got = 1'b0;
        logic bad = 1'b0;
        logic [31:0] sAddr = '0;
        logic [31:0] rd;
        logic er;
        if (portB) begin
            b_req = 1'b1; b_write = wr;
            b_address = addr; b_write_data = wdata;
        end else begin
            a_req = 1'b1; a_write = wr;
            a_address = addr; a_write_data = wdata;
        end
        while (!got && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
            if (mem_read || mem_write) begin
                strobes++;
                sAddr = mem_address;
                if (mem_write !== wr) bad = 1'b1;
            end
            if (mem_read && mem_write) bad = 1'b1;
            if (portB ? a_ack : b_ack) bad = 1'b1;
            got = portB ? b_ack : a_ack;
        end
        rd = portB ? b_read_data : a_read_data;
        er = portB ? b_error : a_error;
        check({tag, "_lat"}, cyc, expLat);
        check({tag, "_strobes"}, strobes, expStrobes);
        if (expStrobes > 0) check({tag, "_addr"}, sAddr, expAddr);
        check({tag, "_rdata"}, rd, expRead);
        check({tag, "_err"}, er, expErr);
        check({tag, "_bad"}, bad, 1'b0);
        a_req = 1'b0;
        b_req = 1'b0;
        @(posedge clk); #1;
        check({tag, "_idle"}, busy, 1'b0);
    endtask

    initial begin
        int nAck;
        int cyc;
        int strobes;
        logic bad;
        logic [3:0] seq;
        reset = 1'b1;
        a_req = 0; a_write = 0; a_address = 0; a_write_data = 0;
        b_req = 0; b_write = 0; b_address = 0; b_write_data = 0;
        a3_req = 0; a3_address = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_owner", owner_b, 1'b0);
        check("rst_acks", {a_ack, b_ack, a_error, b_error}, 4'h0);
        check("rst_strobe", {mem_read, mem_write}, 2'b00);
        check("rst_maddr", mem_address, 32'h0);
        check("rst_ard", a_read_data, 32'h0);
        reset = 1'b0;

        doAccess("a_rd3", 1'b0, 1'b0, 32'd3, 32'h0, 2, 1, 32'd3, 32'h3, 1'b0);
        doAccess("b_wr5", 1'b1, 1'b1, 32'd5, 32'h55, 2, 1, 32'd5, 32'h0, 1'b0);
        doAccess("b_rd5", 1'b1, 1'b0, 32'd5, 32'h0, 2, 1, 32'd5, 32'h55, 1'b0);
        check("a_hold", a_read_data, 32'h3);

`ifdef DATA_MEM_ARB_RANGE_CHECK_EN
        doAccess("a_rng", 1'b0, 1'b0, 32'd20, 32'h0, 1, 0, 32'd0, 32'h0, 1'b1);
`else
        doAccess("a_rng", 1'b0, 1'b0, 32'd20, 32'h0, 2, 1, 32'd20, 32'd20, 1'b0);
`endif

        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        a_req = 1; a_write = 0; a_address = 32'd1;
        b_req = 1; b_write = 0; b_address = 32'd2;
        nAck = 0; bad = 1'b0; seq = 4'h0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (a_ack || b_ack) begin
                if (nAck < 4) seq[nAck] = b_ack;
                if (a_ack) check("tie_ard", a_read_data, 32'd1);
                if (b_ack) check("tie_brd", b_read_data, 32'd2);
                check("tie_owner", owner_b, b_ack);
                nAck++;
            end
            if ((a_ack && b_ack) || (mem_read && mem_write)) bad = 1'b1;
        end
        check("tie_acks", nAck, 4);
        check("tie_order", seq, 4'b1010);
        check("tie_bad", bad, 1'b0);
        a_req = 0; b_req = 0;
        repeat (4) @(posedge clk);
        #1;

        a_req = 1; a_write = 1; a_address = 32'd6; a_write_data = 32'hAA;
        @(posedge clk); #1;
        check("rmid_wr", mem_write, 1'b1);
        reset = 1'b1;
        a_req = 0;
        @(posedge clk); #1;
        check("rmid_wr_drop", mem_write, 1'b0);
        check("rmid_busy", busy, 1'b0);
        check("rmid_ack", a_ack, 1'b0);
        @(posedge clk); #1;
        check("rmid_ack2", a_ack, 1'b0);
        reset = 1'b0;
        a_req = 1; a_write = 0; a_address = 32'd1;
        b_req = 1; b_write = 0; b_address = 32'd2;
        @(posedge clk); #1;
        check("rmid_tie_owner", owner_b, 1'b0);
        check("rmid_tie_busy", busy, 1'b1);
        a_req = 0; b_req = 0;
        repeat (4) @(posedge clk);
        #1;
        check("rmid_idle", busy, 1'b0);

        // Slow instance: request dropped and address changed after grant
        a3_req = 1; a3_address = 32'd7;
        cyc = 0; strobes = 0; bad = 1'b0;
        while (!a3_ack && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 1) begin
                a3_req = 0;
                a3_address = 32'd9;
            end
            if (m3_read) strobes++;
            if (m3_write) bad = 1'b1;
        end
        check("ac3_lat", cyc, 4);
        check("ac3_strobes", strobes, 3);
        check("ac3_rdata", a3_read_data, 32'd7);
        check("ac3_nowr", bad, 1'b0);
        check("ac3_err", a3_error, 1'b0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
